axis_pixel_unpack: RTL and testbench
====================================

// Module: axis_pixel_unpack
// PURPOSE
//  Downstream stage of the Bayes upsampler. Consumes its 32-bit AXI-Stream output, which carries
//  little-endian packed 24-bit RGB pixels (3 words = 4 pixels), and re-emits one pixel per beat
//  on a PIXEL_WIDTH-wide AXI-Stream with start-of-frame (tuser) and end-of-frame (tlast) marks.
//  It feeds the display/VDMA pixel path and reports per-frame pixel counts.
// PARAMETERS
//  C_S_AXIS_TDATA_WIDTH  32  input word width; only 32 is supported.
//  PIXEL_WIDTH           24  output pixel width; only 24 is supported (3 bytes).
//  CNT_WIDTH             16  width of the per-frame pixel counter.
// PORTS
//  clk              in   1          single clock for all logic.
//  rst              in   1          reset, synchronous, active-high.
//  s_axis_tdata     in   32         packed byte stream; byte 0 = [7:0] is the oldest.
//  s_axis_tvalid    in   1          input word valid.
//  s_axis_tlast     in   1          last word of the frame.
//  s_axis_tready    out  1          input word accepted when tvalid & tready.
//  m_axis_tdata     out  24         pixel; byte n of the stream maps to [8n+7:8n].
//  m_axis_tvalid    out  1          pixel valid.
//  m_axis_tuser     out  1          first pixel of the frame.
//  m_axis_tlast     out  1          last pixel of the frame.
//  m_axis_tready    in   1          downstream accepts the pixel.
//  frame_done       out  1          one-cycle pulse after the tlast pixel handshakes.
//  frame_pixels     out  CNT_WIDTH  pixel count of the frame just completed; held until next pulse.
// BEHAVIOUR
//  - Reset values: s_axis_tready=0 for the reset cycle (then 1), m_axis_tvalid=0, tuser=0, tlast=0,
//    frame_done=0, frame_pixels=0. Byte buffer, byte count, frame counter and flags are cleared.
//    A reset mid-frame discards all buffered bytes without emitting them.
//  - State: 56-bit byte buffer buf, byte count cnt (0..7), last_pending, sof flag (1 after reset),
//    and pix_cnt.
//  - s_axis_tready = !rst_q & (cnt <= 3) & !last_pending. This is registered-state only; there is
//    no combinational path from m_axis_tready to s_axis_tready.
//  - Accept: the 4 input bytes are appended above the cnt existing bytes. With tlast, last_pending
//    is set.
//  - m_axis_tvalid = (cnt >= 3) | (last_pending & cnt != 0). tdata = buf[23:0], and the bytes at
//    or above cnt read as zero, so a 1- or 2-byte remainder is zero-padded in the high bytes.
//  - m_axis_tlast = last_pending & (cnt <= 3). m_axis_tuser = sof.
//  - Emit (tvalid & tready): buf shifts right by 3 bytes and cnt -= min(cnt,3).
//  - Simultaneous accept and emit in the same cycle: cnt_next = cnt + 4 - 3, and the shift and the
//    append combine correctly. The maximum occupancy is 7 bytes.
//  - Pixel count: pix_cnt increments on each emit and wraps modulo 2^CNT_WIDTH.
//  - On the tlast emit:
//    - last_pending and pix_cnt are cleared and sof is set.
//    - frame_done pulses on the next cycle, and frame_pixels = pix_cnt+1 (registered with the pulse).
//    - s_axis_tready reasserts on the cycle after the tlast emit, giving a 1-cycle frame gap.
//  - sof clears on the first emit of a frame.
//  - Output stall (m_axis_tready=0): all m_axis_* signals are held stable. tvalid never drops
//    without a handshake.
//  - Latency: the first pixel is valid the cycle after the first input word is accepted.
//    Steady-state output rate is 1 pixel/cycle, with input ready 3 of every 4 cycles.
//  - An input tlast with no preceding word still yields tlast. A single tlast word (4 bytes) gives
//    pixel 0 plus a 1-byte padded pixel with tlast.
// STRUCTURE
//  - Shared package `upsampling_pkg`: BYTES_PER_WORD=4, BYTES_PER_PIX=3, BUF_BYTES=7.
//  - Single flat module. No sub-module: the byte buffer and its control are one tightly coupled
//    datapath.
// TESTING
//  1. Words 33221100, 77665544, BBAA9988 (tlast on the 3rd), m_tready=1 -> pixels 221100 (tuser),
//     554433, 887766, BBAA99 (tlast); frame_done pulse with frame_pixels=4.
//  2. Words 33221100, 77665544 (tlast) -> 221100, 554433, 007766 (tlast); frame_pixels=3.
//  3. 600-word stream incrementing by 11111111 per word, m_tready=1 -> 800 pixels, byte order
//     checked against a model; 1 frame gap cycle; frame_pixels=800. Repeat the frame back-to-back
//     and check that tuser reasserts.
//  4. Random m_tready (50%) and random s_tvalid gaps on the case-3 stream -> identical pixel
//     sequence; outputs stable while stalled; no lost or duplicated byte.
//  5. Assert rst for 1 cycle after 5 words of a frame -> all outputs at reset values; the next
//     frame starts with tuser on 221100 and no stale bytes.
//  6. Single word 33221100 (tlast) -> 221100 (tuser), 000033 (tlast); frame_pixels=2.

Source files
------------

// File: rtl/upsampling_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : upsampling_pkg
//  Purpose  : Shared constants and helpers for the Bayes upsampler pixel path.
//             Describes the byte geometry of packed 24-bit RGB carried on a
//             32-bit AXI-Stream (4 bytes per word, 3 bytes per pixel) and the
//             size of the re-packing byte buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package upsampling_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTES_PER_PIX  = 3;
  // Worst case occupancy: 3 bytes left over plus one freshly appended word.
  localparam int BUF_BYTES      = 7;
  localparam int BUF_BITS       = BUF_BYTES * 8;
  localparam int WORD_BITS      = BYTES_PER_WORD * 8;
  localparam int PIX_BITS       = BYTES_PER_PIX * 8;

  // Byte counter wide enough for 0..BUF_BYTES.
  localparam int BCNT_W         = 3;
  typedef logic [BCNT_W-1:0] bcnt_t;

  localparam bcnt_t C_PIX_BYTES  = bcnt_t'(BYTES_PER_PIX);
  localparam bcnt_t C_WORD_BYTES = bcnt_t'(BYTES_PER_WORD);

  // Number of buffered bytes consumed by one output pixel: a full pixel when
  // available, otherwise the zero-padded remainder at the end of a frame.
  function automatic bcnt_t bytes_per_emit(input bcnt_t cnt);
    return (cnt >= C_PIX_BYTES) ? C_PIX_BYTES : cnt;
  endfunction

endpackage : upsampling_pkg
`default_nettype wire

// File: rtl/axis_pixel_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pixel_unpack
//  Purpose  : Unpacks a 32-bit AXI-Stream of little-endian packed 24-bit RGB
//             pixels (3 words = 4 pixels) into one pixel per beat, marking the
//             first pixel of a frame with tuser and the last with tlast, and
//             reporting the number of pixels in each completed frame.
//  Ports    :
//    clk, rst             single clock, synchronous active-high reset
//    s_axis_tdata/tvalid/tlast/tready   packed byte stream in (byte 0 oldest)
//    m_axis_tdata/tvalid/tuser/tlast/tready  one pixel per beat out
//    frame_done           one-cycle pulse after the tlast pixel handshake
//    frame_pixels         pixel count of the frame just completed (held)
//  Revision : 1.0 - initial release
// ============================================================================
module axis_pixel_unpack
  import upsampling_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,  // only 32 is supported
  parameter int PIXEL_WIDTH          = 24,  // only 24 is supported
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,

  output logic [PIXEL_WIDTH-1:0]          m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic                            frame_done,
  output logic [CNT_WIDTH-1:0]            frame_pixels
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Invariant: every byte of byte_buf_q at or above cnt_q is zero. That makes
  // the low three bytes a correctly zero-padded pixel without any masking.
  logic [BUF_BITS-1:0]  byte_buf_q, byte_buf_d;
  bcnt_t                cnt_q, cnt_d;
  logic                 last_pending_q, last_pending_d;
  logic                 sof_q, sof_d;
  logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0] frame_pixels_q, frame_pixels_d;
  // High for the first cycle after reset so the input stays closed there.
  logic                 rst_q;

  // --------------------------------------------------------------------------
  // Handshakes and output view of the buffer
  // --------------------------------------------------------------------------
  logic                 w_accept;
  logic                 w_emit;
  logic                 w_emit_last;
  bcnt_t                w_cnt_after_emit;
  logic [BUF_BITS-1:0]  w_buf_after_emit;
  logic [BUF_BITS-1:0]  w_append;

  // Input readiness depends on registered state only, so there is no
  // combinational path from m_axis_tready back to s_axis_tready. Accepting
  // at cnt <= 3 keeps the buffer within 7 bytes even without an emit.
  assign s_axis_tready = !rst_q && (cnt_q <= C_PIX_BYTES) && !last_pending_q;

  // A full pixel is ready, or the frame is ending and a 1/2-byte remainder
  // must be flushed as a padded pixel.
  assign m_axis_tvalid = (cnt_q >= C_PIX_BYTES) || (last_pending_q && (cnt_q != '0));
  assign m_axis_tdata  = byte_buf_q[PIX_BITS-1:0];
  assign m_axis_tlast  = last_pending_q && (cnt_q <= C_PIX_BYTES);
  // sof is set while idle between frames; qualifying with tvalid keeps tuser
  // low whenever there is no pixel on the bus.
  assign m_axis_tuser  = sof_q && m_axis_tvalid;

  assign frame_done    = frame_done_q;
  assign frame_pixels  = frame_pixels_q;

  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_emit        = m_axis_tvalid && m_axis_tready;
  assign w_emit_last   = w_emit && m_axis_tlast;

  // --------------------------------------------------------------------------
  // Byte buffer: shift out the emitted pixel first, then append the new word
  // directly above what remains. Accept only happens at cnt <= 3, so after
  // the shift the word lands at byte offset 0..3 and always fits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_after_emit = cnt_q;
    w_buf_after_emit = byte_buf_q;
    if (w_emit) begin
      w_cnt_after_emit = cnt_q - bytes_per_emit(cnt_q);
      w_buf_after_emit = byte_buf_q >> PIX_BITS;
    end

    w_append = {{(BUF_BITS-WORD_BITS){1'b0}}, s_axis_tdata} << {w_cnt_after_emit, 3'b000};

    byte_buf_d = w_buf_after_emit;
    cnt_d      = w_cnt_after_emit;
    if (w_accept) begin
      byte_buf_d = w_buf_after_emit | w_append;
      cnt_d      = w_cnt_after_emit + C_WORD_BYTES;
    end
  end

  // --------------------------------------------------------------------------
  // Frame control: end-of-frame flag, start-of-frame flag, pixel counting
  // --------------------------------------------------------------------------
  always_comb begin
    last_pending_d = last_pending_q;
    sof_d          = sof_q;
    pix_cnt_d      = pix_cnt_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;

    // last_pending blocks further input, so a tlast accept can never
    // coincide with the tlast emit of the same frame.
    if (w_accept && s_axis_tlast) begin
      last_pending_d = 1'b1;
    end

    if (w_emit_last) begin
      last_pending_d = 1'b0;
      sof_d          = 1'b1;
      pix_cnt_d      = '0;
      frame_done_d   = 1'b1;
      frame_pixels_d = pix_cnt_q + CNT_WIDTH'(1);
    end else if (w_emit) begin
      sof_d          = 1'b0;
      pix_cnt_d      = pix_cnt_q + CNT_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q          <= 1'b1;
      byte_buf_q     <= '0;
      cnt_q          <= '0;
      last_pending_q <= 1'b0;
      sof_q          <= 1'b1;
      pix_cnt_q      <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
    end else begin
      rst_q          <= 1'b0;
      byte_buf_q     <= byte_buf_d;
      cnt_q          <= cnt_d;
      last_pending_q <= last_pending_d;
      sof_q          <= sof_d;
      pix_cnt_q      <= pix_cnt_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
    end
  end

endmodule : axis_pixel_unpack
`default_nettype wire

// File: tb/tb_axis_pixel_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pixel_unpack
//  Purpose  : Self-checking bench for axis_pixel_unpack. Expected pixels are
//             derived per frame from the word list as a flat byte stream cut
//             into 3-byte pixels; a monitor compares every output handshake,
//             stall stability and the frame_done / frame_pixels report.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pixel_unpack;

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        frame_done;
  logic [15:0] frame_pixels;

  axis_pixel_unpack #(
    .C_S_AXIS_TDATA_WIDTH(32),
    .PIXEL_WIDTH         (24),
    .CNT_WIDTH           (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          rand_rdy = 1'b0;

  logic [31:0] wq[$];       // words of the frame being sent
  pix_t        exp_q[$];    // expected pixels, in order
  logic [15:0] exp_cnt[$];  // expected frame_pixels per frame
  pix_t        obs_pix[$];  // observed pixels (for literal checks)
  logic [15:0] obs_fp[$];   // observed frame_pixels reports

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: concatenate the frame's words little-endian into a byte stream,
  // cut into 3-byte pixels, zero-pad the final one.
  task automatic model_frame();
    int   nb;
    int   npix;
    pix_t p;
    nb   = 4 * wq.size();
    npix = (nb + 2) / 3;
    for (int k = 0; k < npix; k++) begin
      p.data = '0;
      for (int j = 0; j < 3; j++) begin
        int idx;
        idx = 3 * k + j;
        if (idx < nb) p.data[8*j +: 8] = wq[idx/4][8*(idx%4) +: 8];
      end
      p.user = (k == 0);
      p.last = (k == npix - 1);
      exp_q.push_back(p);
    end
    exp_cnt.push_back(16'(npix));
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake.
  task automatic send_word(input logic [31:0] d, input logic l);
    bit hs;
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      n_fail++;
      $display("FAIL send_word_timeout: got no s_axis_tready, expected handshake within 1000 cycles");
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int nsend, input bit gaps);
    for (int i = 0; i < nsend; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      send_word(wq[i], (i == wq.size() - 1));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_cnt.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_cnt.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pixels / %0d frames outstanding, expected 0",
               exp_q.size(), exp_cnt.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_stream();
    wq.delete();
    for (int i = 0; i < 600; i++) wq.push_back(32'(i) * 32'h11111111);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"},     m_axis_tvalid, 0);
    chk({tag, "_m_tuser"},      m_axis_tuser,  0);
    chk({tag, "_m_tlast"},      m_axis_tlast,  0);
    chk({tag, "_frame_done"},   frame_done,    0);
    chk({tag, "_frame_pixels"}, frame_pixels,  0);
    chk({tag, "_s_tready"},     s_axis_tready, 0);
  endtask

  // Output ready driver.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every handshake, stall stability, and the frame report.
  initial begin
    bit   stall;
    bit   exp_done;
    pix_t held;
    pix_t e;
    stall    = 1'b0;
    exp_done = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_cnt.delete();
        stall    = 1'b0;
        exp_done = 1'b0;
      end else begin
        chk("frame_done", frame_done, exp_done);
        if (exp_done) begin
          chk("s_tready_after_last", s_axis_tready, 1);
          obs_fp.push_back(frame_pixels);
          if (exp_cnt.size() == 0) begin
            n_fail++;
            $display("FAIL frame_pixels: got %0d, expected no report", frame_pixels);
          end else begin
            chk("frame_pixels", frame_pixels, exp_cnt.pop_front());
          end
        end
        exp_done = 1'b0;
        if (stall) begin
          chk("stall_tvalid", m_axis_tvalid, 1);
          chk("stall_tdata",  m_axis_tdata,  held.data);
          chk("stall_tuser",  m_axis_tuser,  held.user);
          chk("stall_tlast",  m_axis_tlast,  held.last);
        end
        stall = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          obs_pix.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast});
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_pixel: got %h, expected no pixel", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("pix_data", m_axis_tdata, e.data);
            chk("pix_user", m_axis_tuser, e.user);
            chk("pix_last", m_axis_tlast, e.last);
            exp_done = e.last;
          end
        end else if (m_axis_tvalid) begin
          stall = 1'b1;
          held  = '{m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: three words -> four pixels
    wq = '{32'h33221100, 32'h77665544, 32'hBBAA9988};
    obs_pix.delete(); obs_fp.delete();
    model_frame();
    send_frame(3, 1'b0);
    wait_drain();
    chk("t1_npix", obs_pix.size(), 4);
    if (obs_pix.size() == 4) begin
      chk("t1_p0", {obs_pix[0].data, obs_pix[0].user, obs_pix[0].last}, {24'h221100, 2'b10});
      chk("t1_p1", {obs_pix[1].data, obs_pix[1].user, obs_pix[1].last}, {24'h554433, 2'b00});
      chk("t1_p2", {obs_pix[2].data, obs_pix[2].user, obs_pix[2].last}, {24'h887766, 2'b00});
      chk("t1_p3", {obs_pix[3].data, obs_pix[3].user, obs_pix[3].last}, {24'hBBAA99, 2'b01});
    end
    chk("t1_fp", (obs_fp.size() == 1) ? obs_fp[0] : 16'hFFFF, 4);

    // 2: two words -> padded third pixel
    wq = '{32'h33221100, 32'h77665544};
    obs_pix.delete(); obs_fp.delete();
    model_frame();
    send_frame(2, 1'b0);
    wait_drain();
    chk("t2_npix", obs_pix.size(), 3);
    if (obs_pix.size() == 3) begin
      chk("t2_p0", {obs_pix[0].data, obs_pix[0].user}, {24'h221100, 1'b1});
      chk("t2_p2", {obs_pix[2].data, obs_pix[2].last}, {24'h007766, 1'b1});
    end
    chk("t2_fp", (obs_fp.size() == 1) ? obs_fp[0] : 16'hFFFF, 3);

    // 3: long stream, two frames back-to-back, full rate
    load_stream();
    obs_pix.delete(); obs_fp.delete();
    model_frame();
    model_frame();
    send_frame(600, 1'b0);
    send_frame(600, 1'b0);
    wait_drain();
    chk("t3_npix", obs_pix.size(), 1600);
    if (obs_pix.size() == 1600) begin
      chk("t3_p1",      obs_pix[1].data,   24'h111100);
      chk("t3_f2_tuser", obs_pix[800].user, 1);
    end
    chk("t3_fp0", (obs_fp.size() == 2) ? obs_fp[0] : 16'hFFFF, 800);

    // 4: random backpressure and input gaps on the same stream
    rand_rdy = 1'b1;
    obs_pix.delete(); obs_fp.delete();
    model_frame();
    send_frame(600, 1'b1);
    wait_drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_npix", obs_pix.size(), 800);
    chk("t4_fp", (obs_fp.size() == 1) ? obs_fp[0] : 16'hFFFF, 800);

    // 5: reset after 5 words of a frame
    model_frame();
    send_frame(5, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    wq = '{32'h33221100, 32'h77665544, 32'hBBAA9988};
    obs_pix.delete(); obs_fp.delete();
    model_frame();
    send_frame(3, 1'b0);
    wait_drain();
    chk("t5_npix", obs_pix.size(), 4);
    if (obs_pix.size() == 4)
      chk("t5_p0", {obs_pix[0].data, obs_pix[0].user}, {24'h221100, 1'b1});

    // 6: single tlast word; first pixel valid the cycle after acceptance
    wq = '{32'h33221100};
    obs_pix.delete(); obs_fp.delete();
    model_frame();
    send_frame(1, 1'b0);
    @(negedge clk);
    chk("t6_latency_tvalid", m_axis_tvalid, 1);
    chk("t6_latency_tdata",  m_axis_tdata,  24'h221100);
    wait_drain();
    chk("t6_npix", obs_pix.size(), 2);
    if (obs_pix.size() == 2)
      chk("t6_p1", {obs_pix[1].data, obs_pix[1].last}, {24'h000033, 1'b1});
    chk("t6_fp", (obs_fp.size() == 1) ? obs_fp[0] : 16'hFFFF, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axis_pixel_unpack
`default_nettype wire
